// File: rtl/data_ram.sv
// Single-port synchronous RAM, 2**ADDR_WIDTH x DATA_WIDTH, registered read (1-clock latency), write-through.
// Asynchronous active-high reset clears every word and the read register at once; no stalls, no backpressure.
module data_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    // Storage is a flop array so the whole memory can be cleared asynchronously.
    // An unknown wren falls into the read branch, so it never writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wren) begin
            r_mem[address] <= data;
            r_q            <= data;
        end else begin
            r_q <= r_mem[address];
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: reset, write/read-back, write-through, full sweep with wrap, async reset.
module tb_data_ram;

    logic       clock;
    logic       reset;
    logic [7:0] address;
    logic       wren;
    logic [7:0] data;
    logic [7:0] q;

    int n_pass;
    int n_total;

    data_ram #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .wren    (wren),
        .data    (data),
        .q       (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present inputs, take one rising edge, then settle 1ns before sampling.
    task automatic cyc(input logic [7:0] a, input logic w, input logic [7:0] d);
        address = a;
        wren    = w;
        data    = d;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        n_total++;
        assert (q === exp) n_pass++;
        else $error("FAIL %s q=%h expected=%h", tag, q, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        wren    = 1'b0;
        address = 8'h00;
        data    = 8'h00;

        // Reset takes effect without a clock edge
        #2 reset = 1'b1;
        #1 chk("reset_q_async", 8'h00);

        // Writes are ignored while reset is held
        cyc(8'h00, 1'b1, 8'hFF);
        chk("reset_write_ignored", 8'h00);
        cyc(8'h01, 1'b1, 8'hC3);
        chk("reset_write_ignored2", 8'h00);

        @(negedge clock);
        reset = 1'b0;
        #1;

        // Read sweep after reset: all zero, including words targeted during reset
        for (int i = 0; i < 20; i++) begin
            cyc(8'(i), 1'b0, 8'hFF);
            chk($sformatf("reset_sweep_%0d", i), 8'h00);
        end

        // Write then read back
        cyc(8'h10, 1'b1, 8'hA5);
        chk("wr_through_10", 8'hA5);
        cyc(8'h00, 1'b0, 8'h00);
        chk("rd_00_between", 8'h00);
        cyc(8'h10, 1'b0, 8'h00);
        chk("rd_back_10", 8'hA5);

        // q must not follow address/data/wren combinationally
        address = 8'h00;
        data    = 8'h99;
        wren    = 1'b1;
        #2 chk("q_holds_between_edges", 8'hA5);

        // Write disabled: data on the bus must not reach memory
        cyc(8'h07, 1'b1, 8'h33);
        chk("wr_07", 8'h33);
        cyc(8'h07, 1'b0, 8'h5A);
        chk("wren0_rd_07", 8'h33);
        cyc(8'h08, 1'b0, 8'h5A);
        chk("rd_08_zero", 8'h00);
        cyc(8'h07, 1'b0, 8'h00);
        chk("wren0_rd_07_again", 8'h33);

        // Read-during-write returns the new data
        cyc(8'h03, 1'b1, 8'h11);
        chk("wr_03_11", 8'h11);
        cyc(8'h03, 1'b0, 8'h00);
        chk("rd_03_11", 8'h11);
        cyc(8'h03, 1'b1, 8'h22);
        chk("rdw_03_22", 8'h22);
        cyc(8'h10, 1'b0, 8'h00);
        chk("rd_10_after_rdw", 8'hA5);
        cyc(8'h03, 1'b0, 8'h00);
        chk("rd_03_22", 8'h22);

        // Full sweep: write data=address everywhere, then read back with wrap
        for (int i = 0; i < 256; i++) begin
            cyc(8'(i), 1'b1, 8'(i));
            chk($sformatf("sweep_wr_%0d", i), 8'(i));
        end
        for (int i = 0; i < 256; i++) begin
            cyc(8'(i), 1'b0, 8'h00);
            chk($sformatf("sweep_rd_%0d", i), 8'(i));
        end
        cyc(8'h00, 1'b0, 8'h00);
        chk("sweep_wrap_0", 8'h00);
        cyc(8'h01, 1'b0, 8'h00);
        chk("sweep_wrap_1", 8'h01);

        // Async reset pulse mid-cycle
        cyc(8'h05, 1'b1, 8'hFF);
        chk("wr_05_ff", 8'hFF);
        wren    = 1'b0;
        address = 8'h05;
        #2 reset = 1'b1;
        #1 chk("async_reset_q", 8'h00);
        #1 reset = 1'b0;
        cyc(8'h05, 1'b0, 8'h00);
        chk("rd_05_after_reset", 8'h00);
        cyc(8'hFF, 1'b0, 8'h00);
        chk("rd_ff_after_reset", 8'h00);
        cyc(8'h10, 1'b0, 8'h00);
        chk("rd_10_after_reset", 8'h00);

        // Normal operation resumes immediately after release
        cyc(8'h05, 1'b1, 8'h6C);
        chk("wr_05_post_reset", 8'h6C);
        cyc(8'hFF, 1'b1, 8'h81);
        chk("wr_ff_post_reset", 8'h81);
        cyc(8'h05, 1'b0, 8'h00);
        chk("rd_05_post_reset", 8'h6C);
        cyc(8'hFF, 1'b0, 8'h00);
        chk("rd_ff_post_reset", 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
